// File: rtl/matrix_accel_sequencer_if.sv
// Column, accelerator and result signal bundle for matrix_accel_sequencer.
// master: the sequencer side. slave: the surrounding fetch logic, accelerator and consumer.
interface matrix_accel_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3
);
    logic                              col_valid;
    logic                              col_ready;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_multiplier;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_multiplicand;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] acc_multiplier;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] acc_multiplicand;
    logic [KERNEL_SIZE-1:0]            acc_mStart;
    logic [KERNEL_SIZE-1:0]            acc_mReady;
    logic [KERNEL_SIZE-1:0]            acc_Add;
    logic                              acc_finalAdd;
    logic [2*DATA_WIDTH-1:0]           acc_finalAccum;
    logic                              acc_finalReady;
    logic                              acc_Rst;
    logic                              res_valid;
    logic                              res_ready;
    logic [2*DATA_WIDTH-1:0]           res_data;
    logic                              busy;
    logic                              timeout_err;

    modport master (
        input  col_valid, col_multiplier, col_multiplicand,
        input  acc_mReady, acc_finalAccum, acc_finalReady, res_ready,
        output col_ready, acc_multiplier, acc_multiplicand, acc_mStart, acc_Add,
        output acc_finalAdd, acc_Rst, res_valid, res_data, busy, timeout_err
    );

    modport slave (
        output col_valid, col_multiplier, col_multiplicand,
        output acc_mReady, acc_finalAccum, acc_finalReady, res_ready,
        input  col_ready, acc_multiplier, acc_multiplicand, acc_mStart, acc_Add,
        input  acc_finalAdd, acc_Rst, res_valid, res_data, busy, timeout_err
    );
endinterface

// File: rtl/matrix_accel_sequencer.sv
// matrix_accel_sequencer: feeds COLS operand columns into matrixAccelerator, folds the
// per-column products with Add pulses, requests the final lane sum and returns it on a
// valid/ready result port. Optional watchdog on the two wait states is enabled by
// defining SEQ_TIMEOUT_EN.
module matrix_accel_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int COLS           = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     Clk,
    input  logic                     Rst,
    matrix_accel_sequencer_if.master bus
);
    localparam int LANE_W = KERNEL_SIZE * DATA_WIDTH;
    localparam int IDX_W  = $clog2(COLS + 1);
    localparam logic [IDX_W-1:0] COLS_IDX = IDX_W'(COLS);

    typedef enum logic [2:0] {
        IDLE, WAIT_MUL, ISSUE, FINAL_ADD, WAIT_FINAL, OUTPUT, CLEAR
    } state_t;

    state_t                   state_reg;
    logic [IDX_W-1:0]         col_idx_reg;
    logic                     col_ready_reg;
    logic [LANE_W-1:0]        mult_reg;
    logic [LANE_W-1:0]        mcand_reg;
    logic [KERNEL_SIZE-1:0]   mstart_reg;
    logic [KERNEL_SIZE-1:0]   add_reg;
    logic                     final_add_reg;
    logic                     acc_rst_reg;
    logic                     res_valid_reg;
    logic [2*DATA_WIDTH-1:0]  res_data_reg;

    logic handshake;
    logic all_ready;
    logic timeout_hit;

    assign handshake = bus.col_valid & col_ready_reg;
    // Every lane must report done; a partial set never releases the wait.
    assign all_ready = &bus.acc_mReady;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;
    logic            in_wait;
    logic            wait_exit;

    // A wait state is left normally when its completion condition holds this cycle.
    assign in_wait     = (state_reg == WAIT_MUL) || (state_reg == WAIT_FINAL);
    assign wait_exit   = ((state_reg == WAIT_MUL) && (mstart_reg == '0) && all_ready) ||
                         ((state_reg == WAIT_FINAL) && bus.acc_finalReady);
    assign timeout_hit = in_wait && !wait_exit && (wd_cnt_reg == WD_LAST);
    assign bus.timeout_err = timeout_err_reg;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Sequencer FSM with all outputs registered; pulse outputs default low every cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg     <= IDLE;
            col_idx_reg   <= '0;
            col_ready_reg <= 1'b1;
            mult_reg      <= '0;
            mcand_reg     <= '0;
            mstart_reg    <= '0;
            add_reg       <= '0;
            final_add_reg <= 1'b0;
            acc_rst_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            mstart_reg  <= '0;
            add_reg     <= '0;
            acc_rst_reg <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            // Counts cycles spent in the current wait state; any state change restarts it.
            wd_cnt_reg <= (in_wait && !wait_exit && !timeout_hit) ? wd_cnt_reg + 1'b1 : '0;
`endif
            if (timeout_hit) begin
`ifdef SEQ_TIMEOUT_EN
                timeout_err_reg <= 1'b1;
`endif
                final_add_reg <= 1'b0;
                acc_rst_reg   <= 1'b1;
                col_idx_reg   <= '0;
                col_ready_reg <= 1'b1;
                state_reg     <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (handshake) begin
                            mult_reg      <= bus.col_multiplier;
                            mcand_reg     <= bus.col_multiplicand;
                            mstart_reg    <= '1;
                            col_idx_reg   <= IDX_W'(1);
                            col_ready_reg <= 1'b0;
                            state_reg     <= WAIT_MUL;
                        end
                    end
                    WAIT_MUL: begin
                        // mReady is stale while mStart is still on the wire.
                        if ((mstart_reg == '0) && all_ready) begin
                            if (col_idx_reg < COLS_IDX) begin
                                col_ready_reg <= 1'b1;
                                state_reg     <= ISSUE;
                            end else begin
                                add_reg   <= '1;
                                state_reg <= FINAL_ADD;
                            end
                        end
                    end
                    ISSUE: begin
                        if (handshake) begin
                            mult_reg      <= bus.col_multiplier;
                            mcand_reg     <= bus.col_multiplicand;
                            mstart_reg    <= '1;
                            add_reg       <= '1;
                            col_idx_reg   <= col_idx_reg + 1'b1;
                            col_ready_reg <= 1'b0;
                            state_reg     <= WAIT_MUL;
                        end
                    end
                    FINAL_ADD: begin
                        final_add_reg <= 1'b1;
                        state_reg     <= WAIT_FINAL;
                    end
                    WAIT_FINAL: begin
                        if (bus.acc_finalReady) begin
                            res_data_reg  <= bus.acc_finalAccum;
                            final_add_reg <= 1'b0;
                            res_valid_reg <= 1'b1;
                            state_reg     <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (bus.res_ready) begin
                            res_valid_reg <= 1'b0;
                            acc_rst_reg   <= 1'b1;
                            state_reg     <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        col_idx_reg   <= '0;
                        col_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                    default: begin
                        col_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.col_ready        = col_ready_reg;
    assign bus.acc_multiplier   = mult_reg;
    assign bus.acc_multiplicand = mcand_reg;
    assign bus.acc_mStart       = mstart_reg;
    assign bus.acc_Add          = add_reg;
    assign bus.acc_finalAdd     = final_add_reg;
    assign bus.acc_Rst          = acc_rst_reg;
    assign bus.res_valid        = res_valid_reg;
    assign bus.res_data         = res_data_reg;
    assign bus.busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_matrix_accel_sequencer.sv
// Bench for matrix_accel_sequencer: a behavioural accelerator (per-lane product and
// accumulator) answers the sequencer, and each result is compared with the plain sum
// of lane products over the columns that were sent.
module tb_matrix_accel_sequencer;
    localparam int DW   = 32;
    localparam int KS   = 3;
    localparam int COLS = 3;
    localparam int TO   = 16;
    localparam int VW   = KS * DW;
    localparam int RW   = 2 * DW;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    matrix_accel_sequencer_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();

    matrix_accel_sequencer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .COLS(COLS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accelerator model state and scoreboard of accepted columns.
    logic [VW-1:0] exp_mult_q[$];
    logic [VW-1:0] exp_mcand_q[$];
    logic [RW-1:0] lane_acc[KS];
    logic [RW-1:0] lane_prod[KS];
    logic [KS-1:0] lanes_all = '1;
    int  lane_cnt[KS];
    int  lane_dly[KS];
    bit  rand_dly   = 1'b0;
    bit  final_hold = 1'b0;
    bit  final_done = 1'b0;
    int  final_wait = 0;
    int  n_first = 0, n_issue_add = 0, n_fold = 0;

    // Behavioural accelerator: sample sequencer outputs on the falling edge, answer there too.
    initial begin
        logic [KS-1:0] rdy_seen;
        logic [RW-1:0] s;
        bus.acc_mReady     = '1;
        bus.acc_finalReady = 1'b0;
        bus.acc_finalAccum = '0;
        for (int i = 0; i < KS; i++) begin
            lane_acc[i] = '0; lane_prod[i] = '0; lane_cnt[i] = 0; lane_dly[i] = 1;
        end
        forever begin
            @(negedge Clk);
            rdy_seen = bus.acc_mReady;
            if (!Rst) begin
                for (int i = 0; i < KS; i++) begin
                    lane_acc[i] = '0; lane_prod[i] = '0; lane_cnt[i] = 0;
                end
                bus.acc_mReady     = '1;
                bus.acc_finalReady = 1'b0;
                final_done         = 1'b0;
            end else begin
                for (int i = 0; i < KS; i++) begin
                    if (lane_cnt[i] > 0) begin
                        lane_cnt[i]--;
                        if (lane_cnt[i] == 0) bus.acc_mReady[i] = 1'b1;
                    end
                end
                if (bus.acc_finalReady) bus.acc_finalReady = 1'b0;
                if (!bus.acc_finalAdd) begin
                    final_done = 1'b0;
                    final_wait = $urandom_range(0, 3);
                end else if (!final_done && !final_hold) begin
                    if (final_wait == 0) begin
                        s = '0;
                        for (int i = 0; i < KS; i++) s += lane_acc[i];
                        bus.acc_finalAccum = s;
                        bus.acc_finalReady = 1'b1;
                        final_done         = 1'b1;
                    end else begin
                        final_wait--;
                    end
                end
                if (bus.acc_Rst) begin
                    for (int i = 0; i < KS; i++) begin
                        lane_acc[i] = '0; lane_prod[i] = '0;
                    end
                end
                if (bus.acc_mStart != '0) begin
                    check_val("mstart_lanes_ready", 128'(rdy_seen), 128'(lanes_all));
                    check_val("mstart_all_lanes", 128'(bus.acc_mStart), 128'(lanes_all));
                    if (bus.acc_Add != '0) begin
                        n_issue_add++;
                        for (int i = 0; i < KS; i++) lane_acc[i] += lane_prod[i];
                    end else begin
                        n_first++;
                    end
                    if (exp_mult_q.size() == 0) begin
                        check_val("mstart_has_column", 128'(0), 128'(1));
                    end else begin
                        check_val("mstart_multiplier", 128'(bus.acc_multiplier), 128'(exp_mult_q.pop_front()));
                        check_val("mstart_multiplicand", 128'(bus.acc_multiplicand), 128'(exp_mcand_q.pop_front()));
                    end
                    for (int i = 0; i < KS; i++) begin
                        lane_prod[i] = RW'(bus.acc_multiplier[i*DW +: DW]) * RW'(bus.acc_multiplicand[i*DW +: DW]);
                        bus.acc_mReady[i] = 1'b0;
                        lane_cnt[i] = rand_dly ? $urandom_range(1, 6) : lane_dly[i];
                    end
                end else if (bus.acc_Add != '0) begin
                    n_fold++;
                    for (int i = 0; i < KS; i++) lane_acc[i] += lane_prod[i];
                end
            end
        end
    end

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_col_ready"}, 128'(bus.col_ready), 128'(1));
        check_val({pfx, "_acc_multiplier"}, 128'(bus.acc_multiplier), 128'(0));
        check_val({pfx, "_acc_multiplicand"}, 128'(bus.acc_multiplicand), 128'(0));
        check_val({pfx, "_ctrl"}, 128'({bus.acc_mStart, bus.acc_Add, bus.acc_finalAdd, bus.acc_Rst,
                                        bus.res_valid, bus.busy, bus.timeout_err}), 128'(0));
        check_val({pfx, "_res_data"}, 128'(bus.res_data), 128'(0));
    endtask

    // Offer one column (called on a falling edge) and hold it until accepted.
    task automatic send_col(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int n;
        bus.col_valid        = 1'b1;
        bus.col_multiplier   = a;
        bus.col_multiplicand = b;
        n = 0;
        while (!bus.col_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check_val("col_accept", 128'(bus.col_ready), 128'(1));
        if (bus.col_ready) begin
            exp_mult_q.push_back(a);
            exp_mcand_q.push_back(b);
        end
        @(negedge Clk);
        bus.col_valid = 1'b0;
    endtask

    // Send COLS columns with random idle gaps; return the expected convolution sum.
    task automatic send_txn(input int gap_max, input bit fixed, output logic [RW-1:0] exp_sum);
        logic [VW-1:0] a, b;
        logic [DW-1:0] x, y;
        exp_sum = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int l = 0; l < KS; l++) begin
                x = fixed ? DW'(l + 1) : DW'($urandom);
                y = fixed ? DW'(l + 4) : DW'($urandom);
                a[l*DW +: DW] = x;
                b[l*DW +: DW] = y;
                exp_sum += RW'(x) * RW'(y);
            end
            repeat ($urandom_range(0, gap_max)) @(negedge Clk);
            send_col(a, b);
        end
    endtask

    task automatic wait_result(input logic [RW-1:0] exp_sum, input int hold);
        int n;
        n = 0;
        while (!bus.res_valid && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check_val("res_valid_seen", 128'(bus.res_valid), 128'(1));
        check_val("res_data", 128'(bus.res_data), 128'(exp_sum));
        repeat (hold) begin
            @(negedge Clk);
            check_val("hold_res_valid", 128'(bus.res_valid), 128'(1));
            check_val("hold_res_data", 128'(bus.res_data), 128'(exp_sum));
            check_val("hold_col_ready", 128'(bus.col_ready), 128'(0));
        end
        bus.res_ready = 1'b1;
        @(negedge Clk);
        bus.res_ready = 1'b0;
        check_val("clear_acc_rst", 128'(bus.acc_Rst), 128'(1));
        check_val("clear_res_valid", 128'(bus.res_valid), 128'(0));
        @(negedge Clk);
        check_val("idle_acc_rst", 128'(bus.acc_Rst), 128'(0));
        check_val("idle_busy_ready", 128'({bus.busy, bus.col_ready}), 128'(2'b01));
    endtask

    task automatic run_txn(input int gap_max, input int hold, input bit fixed);
        logic [RW-1:0] exp_sum;
        n_first = 0; n_issue_add = 0; n_fold = 0;
        send_txn(gap_max, fixed, exp_sum);
        wait_result(exp_sum, hold);
        check_val("first_mstart_count", 128'(n_first), 128'(1));
        check_val("mstart_with_add_count", 128'(n_issue_add), 128'(COLS - 1));
        check_val("final_fold_count", 128'(n_fold), 128'(1));
        $display("txn gap_max=%0d hold=%0d expected_sum=0x%0h got=0x%0h", gap_max, hold, exp_sum, bus.res_data);
    endtask

    task automatic wait_final_add();
        int n;
        n = 0;
        while (!bus.acc_finalAdd && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check_val("final_add_seen", 128'(bus.acc_finalAdd), 128'(1));
    endtask

    initial begin
        logic [RW-1:0] dummy;
        bus.col_valid        = 1'b0;
        bus.col_multiplier   = '0;
        bus.col_multiplicand = '0;
        bus.res_ready        = 1'b0;
        repeat (2) @(negedge Clk);
        check_idle_outputs("reset");
        Rst = 1'b1;
        @(negedge Clk);

        // Fixed columns (1,2,3)x(4,5,6) three times: sum 96, zero-wait lanes.
        lane_dly = '{1, 1, 1};
        run_txn(0, 0, 1'b1);
        check_val("fixed_sum_96", 128'(bus.res_data), 128'(96));

        // Staggered lane completion.
        lane_dly = '{2, 5, 9};
        run_txn(0, 0, 1'b0);

        // Consumer back-pressure for 20 cycles.
        lane_dly = '{1, 1, 1};
        run_txn(2, 20, 1'b0);

        // Random column gaps and random lane latencies.
        rand_dly = 1'b1;
        for (int t = 0; t < 6; t++) run_txn(7, $urandom_range(0, 3), 1'b0);

        // Reset asserted while waiting for the final sum, then a full run.
        final_hold = 1'b1;
        send_txn(3, 1'b0, dummy);
        wait_final_add();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        final_hold = 1'b0;
        exp_mult_q.delete();
        exp_mcand_q.delete();
        @(negedge Clk);
        run_txn(3, 1, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        begin
            int k;
            bit saw_valid;
            final_hold = 1'b1;
            send_txn(1, 1'b0, dummy);
            wait_final_add();
            k = 0;
            saw_valid = 1'b0;
            while (!bus.timeout_err && k < 100) begin
                @(negedge Clk);
                k++;
                if (bus.res_valid) saw_valid = 1'b1;
            end
            check_val("timeout_cycles", 128'(k), 128'(TO));
            check_val("timeout_acc_rst", 128'(bus.acc_Rst), 128'(1));
            check_val("timeout_idle", 128'({bus.busy, bus.acc_finalAdd, bus.col_ready, bus.res_valid}), 128'(4'b0010));
            check_val("timeout_no_result", 128'(saw_valid), 128'(0));
            @(negedge Clk);
            check_val("timeout_rst_pulse_end", 128'(bus.acc_Rst), 128'(0));
            check_val("timeout_sticky", 128'(bus.timeout_err), 128'(1));
            final_hold = 1'b0;
            run_txn(0, 0, 1'b0);
        end
`else
        check_val("timeout_err_tied_low", 128'(bus.timeout_err), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
